// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, wait-state tolerant imem access,
// stall hold buffer, deferred redirects and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        JumpRegD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  input  logic [31:0] PCRegD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] hold_reg, hold_next;
  logic        redir_pend_reg, redir_pend_next;
  logic [31:0] redir_pc_reg, redir_pc_next;
  logic [31:0] instr_reg, pc_plus4_reg;
  logic        valid_reg;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        ifid_load;
  logic        ifid_bubble;
  logic [31:0] ifid_word;

  // A decode-stage redirect only counts for a real instruction that is moving on.
  assign redirect = valid_reg & ~StallF & (JumpRegD | JumpD | BranchD);
  assign redirect_target = JumpRegD ? PCRegD : (JumpD ? PCJumpD : PCBranchD);
  assign pc_plus4 = pc_reg + 32'd4;

  assign imem_req  = (state_reg == FETCH) & ~reset;
  assign imem_addr = pc_reg;
  assign InstrD    = instr_reg;
  assign PCPlus4D  = pc_plus4_reg;
  assign ValidD    = valid_reg;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    hold_next       = hold_reg;
    redir_pend_next = redir_pend_reg;
    redir_pc_next   = redir_pc_reg;
    ifid_load       = 1'b0;
    ifid_bubble     = 1'b0;
    ifid_word       = imem_rdata;

    case (state_reg)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_next         = redirect_target;
            redir_pend_next = 1'b0;
            ifid_bubble     = 1'b1;
          end else if (redir_pend_reg) begin
            // The word returned for the abandoned address is dropped.
            pc_next         = redir_pc_reg;
            redir_pend_next = 1'b0;
            ifid_bubble     = ~StallF;
          end else if (StallF) begin
            hold_next  = imem_rdata;
            state_next = HELD;
          end else begin
            pc_next   = pc_plus4;
            ifid_load = 1'b1;
          end
        end else begin
          // Access still outstanding: the address must stay put, so the
          // redirect is parked until the memory answers.
          if (redirect) begin
            redir_pend_next = 1'b1;
            redir_pc_next   = redirect_target;
            ifid_bubble     = 1'b1;
          end else if (!StallF) begin
            ifid_bubble = 1'b1;
          end
        end
      end
      HELD: begin
        ifid_word = hold_reg;
        if (redirect) begin
          pc_next     = redirect_target;
          state_next  = FETCH;
          ifid_bubble = 1'b1;
        end else if (!StallF) begin
          pc_next    = pc_plus4;
          state_next = FETCH;
          ifid_load  = 1'b1;
        end
      end
      default: state_next = FETCH;
    endcase

    if (FlushD) begin
      ifid_load   = 1'b0;
      ifid_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      hold_reg       <= 32'd0;
      redir_pend_reg <= 1'b0;
      redir_pc_reg   <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      hold_reg       <= hold_next;
      redir_pend_reg <= redir_pend_next;
      redir_pc_reg   <= redir_pc_next;
    end
  end

  // IF/ID register; a bubble keeps PCPlus4D so only the valid/instr fields clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_reg    <= 32'd0;
      pc_plus4_reg <= 32'd0;
      valid_reg    <= 1'b0;
    end else if (ifid_load) begin
      instr_reg    <= ifid_word;
      pc_plus4_reg <= pc_plus4;
      valid_reg    <= 1'b1;
    end else if (ifid_bubble) begin
      instr_reg <= 32'd0;
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset corner
// sequences, then randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, StallF, FlushD, BranchD, JumpD, JumpRegD;
  logic [31:0] PCBranchD, PCJumpD, PCRegD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .FlushD(FlushD),
    .BranchD(BranchD), .JumpD(JumpD), .JumpRegD(JumpRegD),
    .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .PCRegD(PCRegD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  typedef struct {
    logic        rst, stall, flush, br, j, jr, rdy;
    logic [31:0] rdata, tb, tj, tr;
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, stall, flush, br, j, jr, rdy,
                              input logic [31:0] rdata, tb, tj, tr,
                              input logic e_req, input logic [31:0] e_addr, e_instr, e_pc4,
                              input logic e_valid);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush; v.br = br; v.j = j; v.jr = jr; v.rdy = rdy;
    v.rdata = rdata; v.tb = tb; v.tj = tj; v.tr = tr;
    v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, stall, flush, br, j, jr, rdy,
                       input logic [31:0] rdata, tb, tj, tr);
    reset = rst; StallF = stall; FlushD = flush;
    BranchD = br; JumpD = j; JumpRegD = jr; imem_ready = rdy;
    imem_rdata = rdata; PCBranchD = tb; PCJumpD = tj; PCRegD = tr;
  endtask

  // Inputs applied at the falling edge; outputs checked 1ns after the following rising edge.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.rst, v.stall, v.flush, v.br, v.j, v.jr, v.rdy, v.rdata, v.tb, v.tj, v.tr);
    @(posedge clk);
    #1;
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, v.e_req});
    check({tag, ".addr"},  imem_addr, v.e_addr);
    check({tag, ".instr"}, InstrD, v.e_instr);
    check({tag, ".pc4"},   PCPlus4D, v.e_pc4);
    check({tag, ".valid"}, {31'd0, ValidD}, {31'd0, v.e_valid});
    $display("vec %s: addr=%h instr=%h pc4=%h valid=%0b req=%0b",
             tag, imem_addr, InstrD, PCPlus4D, ValidD, imem_req);
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_hold, m_rpc, m_instr, m_pc4;
  logic        m_held, m_pend, m_valid;

  task automatic model_step(input logic rst, stall, flush, br, j, jr, rdy,
                            input logic [31:0] rdata, tb, tj, tr);
    logic        redir, arrives, bubble, deliver;
    logic [31:0] tgt, word, seq;
    if (rst) begin
      m_pc = RESET_PC; m_held = 0; m_pend = 0; m_hold = 0;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      return;
    end
    redir   = m_valid && !stall && (br || j || jr);
    tgt     = jr ? tr : (j ? tj : tb);
    arrives = !m_held && rdy;
    bubble  = 0; deliver = 0; word = 0; seq = 0;
    if (redir) begin
      if (m_held || rdy) begin
        m_pc = tgt; m_pend = 0; m_held = 0;
      end else begin
        m_pend = 1; m_rpc = tgt;
      end
      bubble = 1;
    end else if (arrives && m_pend) begin
      m_pc = m_rpc; m_pend = 0; bubble = !stall;
    end else if ((m_held || arrives) && !stall) begin
      word = m_held ? m_hold : rdata;
      seq  = m_pc + 32'd4;
      m_pc = seq; m_held = 0; deliver = 1;
    end else if (arrives) begin
      m_held = 1; m_hold = rdata;
    end else if (!m_held && !stall) begin
      bubble = 1;
    end
    if (flush) begin
      bubble = 1; deliver = 0;
    end
    if (deliver) begin
      m_instr = word; m_pc4 = seq; m_valid = 1;
    end else if (bubble) begin
      m_instr = 0; m_valid = 0;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst stl fl br j jr rdy rdata tb tj tr | req addr instr pc4 valid
    vecs.push_back(mk(1,0,0,0,0,0,0, 32'h0,         0, 0, 0, 0, 32'h0,  32'h0,         32'h0,  0));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h100,       0, 0, 0, 1, 32'h4,  32'h100,       32'h4,  1));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h104,       0, 0, 0, 1, 32'h8,  32'h104,       32'h8,  1));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h108,       0, 0, 0, 1, 32'hC,  32'h108,       32'hC,  1));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h10C,       0, 0, 0, 1, 32'h10, 32'h10C,       32'h10, 1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'hDEAD,      0, 0, 0, 1, 32'h10, 32'h0,         32'h10, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'hDEAD,      0, 0, 0, 1, 32'h10, 32'h0,         32'h10, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'hDEAD,      0, 0, 0, 1, 32'h10, 32'h0,         32'h10, 0));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h1234_5678, 0, 0, 0, 1, 32'h14, 32'h1234_5678, 32'h14, 1));
    vecs.push_back(mk(0,1,0,0,0,0,1, 32'hAAAA_0000, 0, 0, 0, 0, 32'h14, 32'h1234_5678, 32'h14, 1));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'hDEAD,      0, 0, 0, 0, 32'h14, 32'h1234_5678, 32'h14, 1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'hDEAD,      0, 0, 0, 1, 32'h18, 32'hAAAA_0000, 32'h18, 1));
    vecs.push_back(mk(0,0,0,1,0,0,0, 32'hDEAD,  32'h40, 0, 0, 1, 32'h18, 32'h0,         32'h18, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'hDEAD,      0, 0, 0, 1, 32'h18, 32'h0,         32'h18, 0));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'hBAD0_BAD0, 0, 0, 0, 1, 32'h40, 32'h0,         32'h18, 0));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h40,        0, 0, 0, 1, 32'h44, 32'h40,        32'h44, 1));
    vecs.push_back(mk(0,0,0,0,1,1,1, 32'h55,    0, 32'h90, 32'h80, 1, 32'h80, 32'h0,   32'h44, 0));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h80,        0, 0, 0, 1, 32'h84, 32'h80,        32'h84, 1));
    vecs.push_back(mk(0,0,1,0,0,0,1, 32'h99,        0, 0, 0, 1, 32'h88, 32'h0,         32'h84, 0));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h88,        0, 0, 0, 1, 32'h8C, 32'h88,        32'h8C, 1));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'hDEAD,      0, 0, 0, 1, 32'h8C, 32'h88,        32'h8C, 1));
    vecs.push_back(mk(0,0,0,0,1,0,1, 32'h66,    0, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h8C, 0));
    vecs.push_back(mk(0,0,0,0,0,0,1, 32'h7,         0, 0, 0, 1, 32'h0,  32'h7,         32'h0,  1));

    for (int i = 0; i < vecs.size(); i++)
      run_vec($sformatf("t%0d", i), vecs[i]);

    // Reset while holding a stalled word, then reset with a parked redirect.
    run_vec("h0", mk(0,0,0,0,0,0,1, 32'h11, 0, 0, 0, 1, 32'h4, 32'h11, 32'h4, 1));
    run_vec("h1", mk(0,1,0,0,0,0,1, 32'h22, 0, 0, 0, 0, 32'h4, 32'h11, 32'h4, 1));
    run_vec("h2", mk(1,1,0,0,0,0,1, 32'h22, 0, 0, 0, 0, RESET_PC, 32'h0, 32'h0, 0));
    run_vec("h3", mk(0,0,0,0,0,0,0, 32'h22, 0, 0, 0, 1, RESET_PC, 32'h0, 32'h0, 0));
    run_vec("h4", mk(0,0,0,0,0,0,1, 32'h33, 0, 0, 0, 1, 32'h4, 32'h33, 32'h4, 1));
    run_vec("h5", mk(0,0,0,1,0,0,0, 32'h33, 32'h40, 0, 0, 1, 32'h4, 32'h0, 32'h4, 0));
    run_vec("h6", mk(1,0,0,0,0,0,0, 32'h33, 0, 0, 0, 0, RESET_PC, 32'h0, 32'h0, 0));
    run_vec("h7", mk(0,0,0,0,0,0,1, 32'h44, 0, 0, 0, 1, 32'h4, 32'h44, 32'h4, 1));

    // Randomized traffic; a forced reset first aligns model and DUT.
    for (int c = 0; c < 3000; c++) begin
      logic rst, stl, fl, br, j, jr, rdy;
      logic [31:0] rd, tb, tj, tr;
      rst = (c == 0) || ($urandom_range(0, 149) == 0);
      stl = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 5) == 0);
      j   = ($urandom_range(0, 7) == 0);
      jr  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rd  = $urandom;
      tb  = $urandom & 32'hFFFF_FFFC;
      tj  = $urandom & 32'hFFFF_FFFC;
      tr  = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      drive(rst, stl, fl, br, j, jr, rdy, rd, tb, tj, tr);
      #1;
      if (c != 0) begin
        check($sformatf("r%0d.req", c),  {31'd0, imem_req}, {31'd0, !rst && !m_held});
        check($sformatf("r%0d.addr", c), imem_addr, m_pc);
      end
      model_step(rst, stl, fl, br, j, jr, rdy, rd, tb, tj, tr);
      @(posedge clk);
      #1;
      check($sformatf("r%0d.instr", c), InstrD, m_instr);
      check($sformatf("r%0d.pc4", c),   PCPlus4D, m_pc4);
      check($sformatf("r%0d.valid", c), {31'd0, ValidD}, {31'd0, m_valid});
      $display("rnd %0d: rst=%0b stall=%0b flush=%0b rdy=%0b addr=%h instr=%h valid=%0b",
               c, rst, stl, fl, rdy, imem_addr, InstrD, ValidD);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
